// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-lite encodings plus the state type and strobe decoder used by the
// APB4-to-AHB3-lite bridge.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } apb2ahb_state_t;

  typedef struct packed {
    logic       legal;
    logic [2:0] hsize;
    logic [1:0] offset;
  } strb_decode_t;

  // Only naturally aligned byte, halfword and word strobe patterns map onto one AHB transfer.
  function automatic strb_decode_t strb2hsize(input logic [3:0] pstrb);
    strb_decode_t d;
    d.legal  = 1'b1;
    d.hsize  = HSIZE_WORD;
    d.offset = 2'd0;
    case (pstrb)
      4'b0001: begin d.hsize = HSIZE_BYTE;  d.offset = 2'd0; end
      4'b0010: begin d.hsize = HSIZE_BYTE;  d.offset = 2'd1; end
      4'b0100: begin d.hsize = HSIZE_BYTE;  d.offset = 2'd2; end
      4'b1000: begin d.hsize = HSIZE_BYTE;  d.offset = 2'd3; end
      4'b0011: begin d.hsize = HSIZE_HWORD; d.offset = 2'd0; end
      4'b1100: begin d.hsize = HSIZE_HWORD; d.offset = 2'd2; end
      4'b1111: begin d.hsize = HSIZE_WORD;  d.offset = 2'd0; end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/apb4_ahb3lite_bridge.sv
// APB4 completer that replays each APB access as a single AHB3-lite SINGLE transfer,
// acting as one extra manager port on the AHB crossbar.
module apb4_ahb3lite_bridge
  import ahb3lite_pkg::*;
#(
  parameter int                    HADDR_SIZE = 32,
  parameter int                    HDATA_SIZE = 32,
  parameter int                    PADDR_SIZE = 16,
  parameter int                    PDATA_SIZE = 32,
  parameter logic [HADDR_SIZE-1:0] HADDR_BASE = '0
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,

  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [2:0]              PPROT,
  input  logic [PDATA_SIZE/8-1:0] PSTRB,
  input  logic [PADDR_SIZE-1:0]   PADDR,
  input  logic [PDATA_SIZE-1:0]   PWDATA,
  output logic [PDATA_SIZE-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,

  output logic [HADDR_SIZE-1:0]   HADDR,
  output logic [1:0]              HTRANS,
  output logic [2:0]              HSIZE,
  output logic [2:0]              HBURST,
  output logic [3:0]              HPROT,
  output logic                    HWRITE,
  output logic                    HMASTLOCK,
  output logic [HDATA_SIZE-1:0]   HWDATA,
  input  logic [HDATA_SIZE-1:0]   HRDATA,
  input  logic                    HREADY,
  input  logic                    HRESP
);

  if (HDATA_SIZE != 32) begin : g_bad_hdata
    $error("apb4_ahb3lite_bridge: HDATA_SIZE must be 32");
  end
  if (PDATA_SIZE != HDATA_SIZE) begin : g_bad_pdata
    $error("apb4_ahb3lite_bridge: PDATA_SIZE must equal HDATA_SIZE");
  end
  if (PADDR_SIZE < 3 || PADDR_SIZE > HADDR_SIZE) begin : g_bad_paddr
    $error("apb4_ahb3lite_bridge: PADDR_SIZE out of range");
  end else if (HADDR_BASE[PADDR_SIZE-1:0] != '0) begin : g_bad_base
    $error("apb4_ahb3lite_bridge: HADDR_BASE not aligned to the APB window");
  end

  apb2ahb_state_t          r_state;
  logic [1:0]              r_htrans;
  logic [HADDR_SIZE-1:0]   r_haddr;
  logic [2:0]              r_hsize;
  logic [3:0]              r_hprot;
  logic                    r_hwrite;
  logic [HDATA_SIZE-1:0]   r_hwdata;
  logic [PDATA_SIZE-1:0]   r_prdata;
  logic                    r_pready;
  logic                    r_pslverr;

  strb_decode_t            w_dec;
  logic [HADDR_SIZE-1:0]   w_haddr;
  logic                    w_unused;

  // Reads always fetch the full aligned word; writes derive size and lane from the strobes.
  always_comb begin
    w_dec = strb2hsize(PSTRB);
    if (!PWRITE) begin
      w_dec.legal  = 1'b1;
      w_dec.hsize  = HSIZE_WORD;
      w_dec.offset = 2'd0;
    end
  end

  assign w_haddr  = HADDR_BASE | HADDR_SIZE'({PADDR[PADDR_SIZE-1:2], w_dec.offset});
  assign w_unused = ^{PPROT[1], PADDR[1:0]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state   <= ST_IDLE;
      r_htrans  <= HTRANS_IDLE;
      r_haddr   <= '0;
      r_hsize   <= '0;
      r_hprot   <= '0;
      r_hwrite  <= 1'b0;
      r_hwdata  <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      r_pready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (PSEL && !PENABLE) begin
            r_haddr  <= w_haddr;
            r_hsize  <= w_dec.hsize;
            r_hwrite <= PWRITE;
            r_hprot  <= {2'b00, PPROT[0], ~PPROT[2]};
            if (PWRITE) begin
              r_hwdata <= PWDATA;
            end
            // An unmappable strobe pattern is refused without touching the AHB side.
            if (w_dec.legal) begin
              r_htrans <= HTRANS_NONSEQ;
              r_state  <= ST_ADDR;
            end else begin
              r_pready  <= 1'b1;
              r_pslverr <= 1'b1;
              r_state   <= ST_RESP;
            end
          end
        end
        ST_ADDR: begin
          if (HREADY) begin
            r_htrans <= HTRANS_IDLE;
            r_state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          // HRESP alone is the first half of a two-cycle error; only HREADY ends the phase.
          if (HREADY) begin
            if (!r_hwrite) begin
              r_prdata <= HRDATA;
            end
            r_pready  <= 1'b1;
            r_pslverr <= HRESP;
            r_state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_pslverr <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign HADDR     = r_haddr;
  assign HTRANS    = r_htrans;
  assign HSIZE     = r_hsize;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = r_hprot;
  assign HWRITE    = r_hwrite;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = r_hwdata;
  assign PRDATA    = r_prdata;
  assign PREADY    = r_pready;
  assign PSLVERR   = r_pslverr;

endmodule

// File: tb/tb_apb4_ahb3lite_bridge.sv
// Directed and randomised APB traffic through the bridge into a behavioural AHB memory
// with programmable wait states and error responses.
`timescale 1ns/1ps
module tb_apb4_ahb3lite_bridge;
  import ahb3lite_pkg::*;

  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [2:0]  PPROT = '0;
  logic [3:0]  PSTRB = '0;
  logic [15:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HWRITE, HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1, HRESP = 1'b0;

  int checks = 0;
  int errors = 0;

  int addrWait = 0, dataWait = 0;
  bit errInject = 0;
  int nonseqCount = 0;
  bit busAttrBad = 0, haddrMoved = 0;
  logic [31:0] lastAddr = '0, lastHwdata = '0;
  logic [2:0]  lastSize = '0;
  logic        lastWrite = 1'b0;
  logic [3:0]  lastHprot = '0;

  logic [31:0] mem [0:16383];
  logic [31:0] shadow [0:15];
  logic [3:0]  legalStrb [0:6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

  apb4_ahb3lite_bridge #(
    .HADDR_SIZE(32), .HDATA_SIZE(32), .PADDR_SIZE(16), .PDATA_SIZE(32), .HADDR_BASE(BASE)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PPROT(PPROT), .PSTRB(PSTRB),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HWRITE(HWRITE), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  // Compares one observed value against its expected value and reports any difference.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one complete APB access and returns read data, error flag and access-cycle count.
  task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [3:0] strb,
                               input logic [31:0] wdata, input logic [2:0] prot,
                               output logic [31:0] rdata, output logic slverr, output int cycles);
    int n;
    bit done;
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PSTRB = strb; PWDATA = wdata; PPROT = prot;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    n = 0; done = 0; rdata = '0; slverr = 1'b0;
    while (!done && n < 50) begin
      @(negedge HCLK);
      n++;
      if (PREADY) begin
        done = 1;
        rdata = PRDATA;
        slverr = PSLVERR;
      end
    end
    cycles = done ? n : -1;
    checkOutput("apbCompleted", 64'(done), 64'(1));
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Behavioural AHB memory: stretches address/data phases and injects two-cycle errors on request.
  initial begin : ahbSlave
    bit dpValid, dpDone, apDone, dpWrite;
    int dpCnt, apCnt, off;
    logic [31:0] dpAddr, apHoldAddr;
    logic [2:0]  dpSize;
    dpValid = 0; dpDone = 0; apDone = 0; dpWrite = 0; dpCnt = 0; apCnt = 0;
    dpAddr = '0; apHoldAddr = '0; dpSize = '0;
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) mem[256 + i] = 32'hA500_0000 | 32'(i * 32'h0101);
    mem[4] = 32'hDEADBEEF;
    mem[1] = 32'h11223344;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        dpValid = 0; dpDone = 0; apDone = 0; apCnt = 0;
        HREADY = 1'b1; HRESP = 1'b0;
      end else begin
        if (HBURST != HBURST_SINGLE || HMASTLOCK) busAttrBad = 1;
        if (dpDone) begin dpValid = 0; dpDone = 0; end
        if (apDone) begin dpValid = 1; dpCnt = dataWait; apDone = 0; end
        HREADY = 1'b1; HRESP = 1'b0;
        if (dpValid) begin
          if (dpCnt > 0) begin
            HREADY = 1'b0;
            HRESP = errInject && dpCnt == 1;
            dpCnt--;
          end else begin
            HRESP = errInject;
            lastHwdata = HWDATA;
            off = int'(dpAddr[1:0]);
            if (dpWrite) begin
              case (dpSize)
                3'd0:    mem[dpAddr[15:2]][off*8 +: 8] = HWDATA[off*8 +: 8];
                3'd1:    mem[dpAddr[15:2]][off*8 +: 16] = HWDATA[off*8 +: 16];
                default: mem[dpAddr[15:2]] = HWDATA;
              endcase
            end else begin
              HRDATA = mem[dpAddr[15:2]];
            end
            dpDone = 1;
          end
        end else if (HTRANS == HTRANS_NONSEQ) begin
          nonseqCount++;
          if (apCnt == 0) apHoldAddr = HADDR;
          else if (HADDR != apHoldAddr) haddrMoved = 1;
          if (apCnt < addrWait) begin
            HREADY = 1'b0;
            apCnt++;
          end else begin
            dpAddr = HADDR; dpSize = HSIZE; dpWrite = HWRITE;
            lastAddr = HADDR; lastSize = HSIZE; lastWrite = HWRITE; lastHprot = HPROT;
            apDone = 1;
            apCnt = 0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] rd, d;
    logic        err, wr;
    logic [3:0]  s;
    int          cyc, ns0, w;

    for (int i = 0; i < 16; i++) shadow[i] = 32'hA500_0000 | 32'(i * 32'h0101);

    repeat (3) @(negedge HCLK);
    checkOutput("rstAhbCtrl", 64'({HTRANS, HSIZE, HWRITE, HPROT}), 64'(0));
    checkOutput("rstHaddr", 64'(HADDR), 64'(0));
    checkOutput("rstHwdata", 64'(HWDATA), 64'(0));
    checkOutput("rstApb", 64'({PRDATA, PREADY, PSLVERR}), 64'(0));
    #2 HRESETn = 1'b1;

    $display("[TB] word read");
    applyStimulus(1'b0, 16'h0010, 4'h0, 32'h0, 3'b000, rd, err, cyc);
    checkOutput("rdData", 64'(rd), 64'(32'hDEADBEEF));
    checkOutput("rdErr", 64'(err), 64'(0));
    checkOutput("rdCycles", 64'(cyc), 64'(3));
    checkOutput("rdHaddr", 64'(lastAddr), 64'(32'h2000_0010));
    checkOutput("rdHsize", 64'(lastSize), 64'(HSIZE_WORD));
    checkOutput("rdHwrite", 64'(lastWrite), 64'(0));
    checkOutput("rdHprot", 64'(lastHprot), 64'(4'b0001));

    applyStimulus(1'b0, 16'h0013, 4'h0, 32'h0, 3'b101, rd, err, cyc);
    checkOutput("rdLowBitsData", 64'(rd), 64'(32'hDEADBEEF));
    checkOutput("rdLowBitsHaddr", 64'(lastAddr), 64'(32'h2000_0010));
    checkOutput("rdProtHprot", 64'(lastHprot), 64'(4'b0010));

    $display("[TB] sub-word writes");
    applyStimulus(1'b1, 16'h0004, 4'b0100, 32'h00AB_0000, 3'b000, rd, err, cyc);
    checkOutput("wrByteHaddr", 64'(lastAddr), 64'(BASE + 32'h6));
    checkOutput("wrByteHsize", 64'(lastSize), 64'(HSIZE_BYTE));
    checkOutput("wrByteHwrite", 64'(lastWrite), 64'(1));
    checkOutput("wrByteHwdata", 64'(lastHwdata), 64'(32'h00AB_0000));
    checkOutput("wrByteErr", 64'(err), 64'(0));
    checkOutput("wrByteCycles", 64'(cyc), 64'(3));
    applyStimulus(1'b0, 16'h0004, 4'h0, 32'h0, 3'b000, rd, err, cyc);
    checkOutput("wrByteReadback", 64'(rd), 64'(32'h11AB_3344));

    applyStimulus(1'b1, 16'h0004, 4'b1100, 32'hCAFE_0000, 3'b000, rd, err, cyc);
    checkOutput("wrHalfHaddr", 64'(lastAddr), 64'(BASE + 32'h6));
    checkOutput("wrHalfHsize", 64'(lastSize), 64'(HSIZE_HWORD));
    applyStimulus(1'b0, 16'h0004, 4'h0, 32'h0, 3'b000, rd, err, cyc);
    checkOutput("wrHalfReadback", 64'(rd), 64'(32'hCAFE_3344));

    applyStimulus(1'b1, 16'h0007, 4'b1111, 32'h0102_0304, 3'b000, rd, err, cyc);
    checkOutput("wrWordHaddr", 64'(lastAddr), 64'(BASE + 32'h4));
    checkOutput("wrWordHsize", 64'(lastSize), 64'(HSIZE_WORD));
    applyStimulus(1'b1, 16'h0004, 4'b0001, 32'h0000_00FF, 3'b000, rd, err, cyc);
    checkOutput("wrLane0Haddr", 64'(lastAddr), 64'(BASE + 32'h4));
    applyStimulus(1'b0, 16'h0004, 4'h0, 32'h0, 3'b000, rd, err, cyc);
    checkOutput("wrMixReadback", 64'(rd), 64'(32'h0102_03FF));

    $display("[TB] illegal strobes");
    ns0 = nonseqCount;
    applyStimulus(1'b1, 16'h0008, 4'b0101, 32'hFFFF_FFFF, 3'b000, rd, err, cyc);
    checkOutput("illegal0101Err", 64'(err), 64'(1));
    checkOutput("illegal0101Cycles", 64'(cyc), 64'(1));
    applyStimulus(1'b1, 16'h0008, 4'b0000, 32'hFFFF_FFFF, 3'b000, rd, err, cyc);
    checkOutput("illegal0000Err", 64'(err), 64'(1));
    checkOutput("illegalNoNonseq", 64'(nonseqCount - ns0), 64'(0));
    applyStimulus(1'b0, 16'h0008, 4'h0, 32'h0, 3'b000, rd, err, cyc);
    checkOutput("illegalMemUntouched", 64'(rd), 64'(0));

    $display("[TB] wait states and error response");
    addrWait = 3; dataWait = 2;
    ns0 = nonseqCount;
    applyStimulus(1'b0, 16'h0010, 4'h0, 32'h0, 3'b000, rd, err, cyc);
    checkOutput("waitCycles", 64'(cyc), 64'(8));
    checkOutput("waitNonseqHeld", 64'(nonseqCount - ns0), 64'(4));
    checkOutput("waitHaddrStable", 64'(haddrMoved), 64'(0));
    checkOutput("waitData", 64'(rd), 64'(32'hDEADBEEF));
    addrWait = 0; dataWait = 1; errInject = 1;
    applyStimulus(1'b1, 16'h000C, 4'b1111, 32'h1234_5678, 3'b000, rd, err, cyc);
    checkOutput("errSlverr", 64'(err), 64'(1));
    checkOutput("errCycles", 64'(cyc), 64'(4));
    errInject = 0; dataWait = 0;
    applyStimulus(1'b0, 16'h0010, 4'h0, 32'h0, 3'b000, rd, err, cyc);
    checkOutput("postErrSlverr", 64'(err), 64'(0));

    $display("[TB] reset during data phase");
    dataWait = 5;
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0020; PSTRB = 4'hF;
    PWDATA = 32'h5555_AAAA; PPROT = 3'b000;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(posedge HCLK);
    @(posedge HCLK); #2;
    checkOutput("preAbortHwdata", 64'(HWDATA), 64'(32'h5555_AAAA));
    checkOutput("preAbortHtrans", 64'(HTRANS), 64'(HTRANS_IDLE));
    HRESETn = 1'b0;
    #1;
    checkOutput("abortHaddr", 64'(HADDR), 64'(0));
    checkOutput("abortHwdata", 64'(HWDATA), 64'(0));
    checkOutput("abortCtrl", 64'({HTRANS, HSIZE, HWRITE, HPROT}), 64'(0));
    checkOutput("abortApb", 64'({PREADY, PSLVERR}), 64'(0));
    PSEL = 1'b0; PENABLE = 1'b0;
    dataWait = 0;
    @(negedge HCLK);
    @(negedge HCLK);
    #2 HRESETn = 1'b1;
    applyStimulus(1'b0, 16'h0010, 4'h0, 32'h0, 3'b000, rd, err, cyc);
    checkOutput("postAbortData", 64'(rd), 64'(32'hDEADBEEF));
    checkOutput("postAbortCycles", 64'(cyc), 64'(3));
    checkOutput("postAbortErr", 64'(err), 64'(0));

    $display("[TB] random back-to-back traffic");
    for (int i = 0; i < 100; i++) begin
      w  = int'($urandom_range(0, 15));
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
      s  = legalStrb[$urandom_range(0, 6)];
      addrWait = int'($urandom_range(0, 2));
      dataWait = int'($urandom_range(0, 2));
      applyStimulus(wr, 16'(32'h0400 + w * 4), wr ? s : 4'h0, d, 3'b000, rd, err, cyc);
      if (wr) begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) shadow[w][b*8 +: 8] = d[b*8 +: 8];
        end
      end else begin
        checkOutput("rndReadData", 64'(rd), 64'(shadow[w]));
      end
      checkOutput("rndSlverr", 64'(err), 64'(0));
    end
    addrWait = 0; dataWait = 0;
    checkOutput("busAttrSingleUnlocked", 64'(busAttrBad), 64'(0));
    checkOutput("haddrStableAll", 64'(haddrMoved), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
